// File: rtl/lot_pkg.sv
// Shared types and default sizing for the parking-lot gate controller.
package lot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        F1   = 2'd1,
        F2   = 2'd2,
        F3   = 2'd3
    } pass_state_t;

    localparam int DEF_CAPACITY = 25;
    localparam int DEF_WIDTH    = 5;

endpackage

// File: rtl/pass_fsm.sv
// Detects one complete car passage through a two-beam gate (a then b, both
// cleared in order); reversals and illegal jumps never produce a pulse.
module pass_fsm
    import lot_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic pass,
    output logic busy
);

    pass_state_t state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pass  <= 1'b0;
        end else begin
            pass <= 1'b0;
            unique case (state)
                IDLE: begin
                    if ({a, b} == 2'b10) state <= F1;
                end
                F1: begin
                    case ({a, b})
                        2'b11:        state <= F2;
                        2'b00, 2'b01: state <= IDLE;
                        default:      state <= F1;
                    endcase
                end
                F2: begin
                    case ({a, b})
                        2'b01:   state <= F3;
                        2'b10:   state <= F1;
                        2'b00:   state <= IDLE;
                        default: state <= F2;
                    endcase
                end
                F3: begin
                    // Only a clean exit from F3 counts as a completed passage.
                    case ({a, b})
                        2'b00: begin
                            state <= IDLE;
                            pass  <= 1'b1;
                        end
                        2'b11:   state <= F2;
                        2'b10:   state <= IDLE;
                        default: state <= F3;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/lot_gate_ctrl.sv
// Parking-lot gate controller: synchronizes gate sensors, detects passages and
// drives the external occupancy counter, gate-open commands and status flags.
module lot_gate_ctrl
    import lot_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ent_a,
    input  logic             ent_b,
    input  logic             ext_a,
    input  logic             ext_b,
    input  logic [WIDTH-1:0] count,
    output logic             inc,
    output logic             dec,
    output logic             ent_open,
    output logic             ext_open,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

    // Bit order {ent_a, ent_b, ext_a, ext_b}.
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       ent_pass;
    logic       ent_busy;
    logic       ext_pass;
    logic       ext_busy;

    pass_fsm u_ent (
        .clk   (clk),
        .reset (reset),
        .a     (sync2[3]),
        .b     (sync2[2]),
        .pass  (ent_pass),
        .busy  (ent_busy)
    );

    pass_fsm u_ext (
        .clk   (clk),
        .reset (reset),
        .a     (sync2[1]),
        .b     (sync2[0]),
        .pass  (ext_pass),
        .busy  (ext_busy)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            inc      <= 1'b0;
            dec      <= 1'b0;
            ent_open <= 1'b1;
            ext_open <= 1'b0;
            full     <= 1'b0;
            empty    <= 1'b1;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
        end else begin
            sync1 <= {ent_a, ent_b, ext_a, ext_b};
            sync2 <= sync1;
            inc   <= 1'b0;
            dec   <= 1'b0;
            // Simultaneous entry and exit cancel out, so neither command nor error.
            if (ent_pass && !ext_pass) begin
                if (count < CAP) inc <= 1'b1;
                else             ovf_err <= 1'b1;
            end else if (ext_pass && !ent_pass) begin
                if (count != '0) dec <= 1'b1;
                else             unf_err <= 1'b1;
            end
            full     <= (count == CAP);
            empty    <= (count == '0);
            ent_open <= !full || ent_busy;
            ext_open <= ext_busy || sync2[1];
        end
    end

endmodule

// File: tb/tb_lot_gate_ctrl.sv
// Self-checking bench for lot_gate_ctrl: a scoreboard queue holds the expected
// inc/dec result of each completed passage, keyed by the clock edge it is due.
module tb_lot_gate_ctrl;

    typedef struct {
        int    cyc;
        logic  inc;
        logic  dec;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ent_a = 1'b0;
    logic       ent_b = 1'b0;
    logic       ext_a = 1'b0;
    logic       ext_b = 1'b0;
    logic [4:0] count = 5'd0;
    logic       inc, dec, ent_open, ext_open, full, empty, ovf_err, unf_err;

    exp_t sbq[$];
    exp_t mon_e;
    int   edgeCnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   monOn = 1'b0;

    lot_gate_ctrl #(.CAPACITY(25), .WIDTH(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .ent_a    (ent_a),
        .ent_b    (ent_b),
        .ext_a    (ext_a),
        .ext_b    (ext_b),
        .count    (count),
        .inc      (inc),
        .dec      (dec),
        .ent_open (ent_open),
        .ext_open (ext_open),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    // Every cycle: the due scoreboard entry is compared, otherwise inc/dec must be idle.
    always @(posedge clk) begin
        edgeCnt = edgeCnt + 1;
        #1;
        if (monOn) begin
            if (sbq.size() > 0 && sbq[0].cyc == edgeCnt) begin
                mon_e = sbq.pop_front();
                checkOutput({mon_e.tag, "_inc"}, 32'(inc), 32'(mon_e.inc));
                checkOutput({mon_e.tag, "_dec"}, 32'(dec), 32'(mon_e.dec));
            end else begin
                checkOutput("idle_inc", 32'(inc), 32'd0);
                checkOutput("idle_dec", 32'(dec), 32'd0);
            end
            if (sbq.size() > 0 && sbq[0].cyc < edgeCnt) begin
                checkOutput("sb_missed", 32'(sbq[0].cyc), 32'(edgeCnt));
                void'(sbq.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] v, input int hold, input bit push,
                                 input logic ei, input logic ed, input string tag);
        exp_t e;
        @(negedge clk);
        {ent_a, ent_b, ext_a, ext_b} = v;
        if (push) begin
            e.cyc = edgeCnt + 4;
            e.inc = ei;
            e.dec = ed;
            e.tag = tag;
            sbq.push_back(e);
        end
        repeat (hold) @(posedge clk);
    endtask

    task automatic doPass(input bit entG, input bit extG, input logic ei, input logic ed,
                          input string tag);
        logic [1:0] seq [4];
        logic [1:0] s;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 4; i++) begin
            s = seq[i];
            applyStimulus({entG ? s : 2'b00, extG ? s : 2'b00}, 4, i == 3, ei, ed, tag);
        end
    endtask

    task automatic checkResetVals(input string tag);
        checkOutput({tag, "_inc"},      32'(inc),      32'd0);
        checkOutput({tag, "_dec"},      32'(dec),      32'd0);
        checkOutput({tag, "_ent_open"}, 32'(ent_open), 32'd1);
        checkOutput({tag, "_ext_open"}, 32'(ext_open), 32'd0);
        checkOutput({tag, "_full"},     32'(full),     32'd0);
        checkOutput({tag, "_empty"},    32'(empty),    32'd1);
        checkOutput({tag, "_ovf"},      32'(ovf_err),  32'd0);
        checkOutput({tag, "_unf"},      32'(unf_err),  32'd0);
    endtask

    initial begin
        reset = 1'b0;
        count = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetVals("rst");
        monOn = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("empty_cnt3", 32'(empty), 32'd0);
        checkOutput("ent_open_idle", 32'(ent_open), 32'd1);
        checkOutput("ext_open_idle", 32'(ext_open), 32'd0);

        applyStimulus(4'b0000, 4, 1'b0, 1'b0, 1'b0, "pre");
        doPass(1'b1, 1'b0, 1'b1, 1'b0, "ent_pass");
        repeat (4) @(negedge clk);
        checkOutput("ovf_after_ent", 32'(ovf_err), 32'd0);

        // Car backs out of the entry gate.
        applyStimulus(4'b1000, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b1100, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b1000, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0000, 4, 1'b0, 1'b0, 1'b0, "");
        @(negedge clk);
        checkOutput("backout_idle", 32'(dut.u_ent.busy), 32'd0);

        // Normal exit with occupancy 3, watching the exit gate open mid-pass.
        applyStimulus(4'b0010, 4, 1'b0, 1'b0, 1'b0, "");
        @(negedge clk);
        checkOutput("ext_open_mid", 32'(ext_open), 32'd1);
        applyStimulus(4'b0011, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0001, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0000, 4, 1'b1, 1'b0, 1'b1, "ext_pass");
        repeat (4) @(negedge clk);
        checkOutput("ext_open_after", 32'(ext_open), 32'd0);

        // Lot full: entry pass must be refused and flagged.
        count = 5'd25;
        repeat (3) @(negedge clk);
        checkOutput("full_flag", 32'(full), 32'd1);
        checkOutput("ent_open_full", 32'(ent_open), 32'd0);
        applyStimulus(4'b1000, 4, 1'b0, 1'b0, 1'b0, "");
        @(negedge clk);
        checkOutput("ent_open_midgate", 32'(ent_open), 32'd1);
        applyStimulus(4'b1100, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0100, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0000, 4, 1'b1, 1'b0, 1'b0, "ovf_pass");
        repeat (3) @(negedge clk);
        checkOutput("ovf_set", 32'(ovf_err), 32'd1);
        checkOutput("ent_open_full_idle", 32'(ent_open), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("ovf_sticky", 32'(ovf_err), 32'd1);

        // Lot empty: exit pass must be refused and flagged.
        count = 5'd0;
        repeat (3) @(negedge clk);
        checkOutput("empty_flag", 32'(empty), 32'd1);
        checkOutput("unf_clear", 32'(unf_err), 32'd0);
        doPass(1'b0, 1'b1, 1'b0, 1'b0, "unf_pass");
        repeat (3) @(negedge clk);
        checkOutput("unf_set", 32'(unf_err), 32'd1);
        checkOutput("empty_after", 32'(empty), 32'd1);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        count = 5'd10;
        repeat (3) @(negedge clk);
        checkOutput("ovf_cleared", 32'(ovf_err), 32'd0);
        doPass(1'b1, 1'b1, 1'b0, 1'b0, "both_pass");
        repeat (3) @(negedge clk);
        checkOutput("both_ovf", 32'(ovf_err), 32'd0);
        checkOutput("both_unf", 32'(unf_err), 32'd0);

        // Reset while the entry FSM sits in F2.
        applyStimulus(4'b1000, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b1100, 4, 1'b0, 1'b0, 1'b0, "");
        @(negedge clk);
        checkOutput("ent_in_f2", 32'(dut.u_ent.state), 32'd2);
        reset = 1'b0;
        @(negedge clk);
        checkResetVals("rst_mid");
        reset = 1'b1;
        applyStimulus(4'b0100, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0000, 4, 1'b0, 1'b0, 1'b0, "");
        @(negedge clk);
        checkOutput("rst_mid_idle", 32'(dut.u_ent.busy), 32'd0);

        // Reset lands on the edge where inc would have been registered.
        applyStimulus(4'b1000, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b1100, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0100, 4, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(4'b0000, 3, 1'b0, 1'b0, 1'b0, "");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        monOn = 1'b0;
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lot_gate_ctrl.md
LOT_GATE_CTRL -- requirements
Module: lot_gate_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 25, meaning the maximum lot occupancy.
REQ-002 SHALL have parameter WIDTH, default 5, meaning the occupancy count width.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 SHALL have ports ent_a, ent_b, input, 1 each, entry-gate photosensors (a = street side, b = lot side), asynchronous, 1 = beam blocked.
REQ-006 SHALL have ports ext_a, ext_b, input, 1 each, exit-gate photosensors (a = lot side, b = street side), asynchronous, 1 = beam blocked.
REQ-007 SHALL have port count, input, WIDTH, current occupancy returned by the external saturating up/down counter.
REQ-008 SHALL have ports inc, dec, output, 1 each, single-cycle increment/decrement commands to that counter.
REQ-009 SHALL have ports ent_open, ext_open, output, 1 each, gate-open commands.
REQ-010 SHALL have ports full, empty, output, 1 each, registered occupancy flags.
REQ-011 SHALL have ports ovf_err, unf_err, output, 1 each, sticky error flags.

Function
REQ-012 SHALL pass each of the four sensor inputs through a 2-flop synchronizer before any use.
REQ-013 SHALL run one pass-detector FSM per gate on the synchronized pair {a,b}, with states IDLE, F1 (10), F2 (11), F3 (01).
REQ-014 Pass-detector transitions SHALL be: IDLE -10-> F1; F1 -11-> F2, F1 -00/01-> IDLE; F2 -01-> F3, F2 -10-> F1, F2 -00-> IDLE; F3 -00-> IDLE plus pass pulse, F3 -11-> F2, F3 -10-> IDLE; every other input holds the current state.
REQ-015 A reversed sequence (car backs out) or an illegal jump SHALL produce no pass pulse.
REQ-016 Each FSM SHALL drive a registered one-cycle pass pulse.
REQ-017 The controller SHALL register inc or dec one cycle after the pass pulse, so inc/dec rises at edge k+3 when edge k is the first edge sampling raw 00.
REQ-018 Entry pass alone SHALL give inc=1 only if count < CAPACITY; otherwise inc=0 and ovf_err is set.
REQ-019 Exit pass alone SHALL give dec=1 only if count > 0; otherwise dec=0 and unf_err is set.
REQ-020 Simultaneous entry and exit passes in the same cycle SHALL produce inc=0 and dec=0 (net zero) and set no error flag.
REQ-021 inc and dec SHALL never both be 1 in the same cycle.
REQ-022 full SHALL be registered as (count == CAPACITY); empty SHALL be registered as (count == 0).
REQ-023 ent_open SHALL be registered as (~full OR entry FSM not IDLE), so a car already mid-gate is never trapped.
REQ-024 ext_open SHALL be registered as 1 whenever the exit FSM is not IDLE or the synchronized ext_a = 1; otherwise 0.
REQ-025 ovf_err and unf_err SHALL stay at 1 until reset.

Reset
REQ-026 While reset=0 at a clk edge: synchronizers cleared to 0, both FSMs to IDLE, inc=dec=0, ent_open=1, ext_open=0, full=0, empty=1, ovf_err=unf_err=0.
REQ-027 Reset asserted mid-pass SHALL abort the pass with no inc/dec emitted, including any pulse already in flight.

Structure
REQ-028 Package lot_pkg SHALL hold the pass-FSM state enum (IDLE, F1, F2, F3) and the default CAPACITY/WIDTH constants.
REQ-029 The pass detector SHALL be sub-module pass_fsm (inputs clk, reset, a, b; output pass), instantiated twice.

Verification
REQ-030 Entry sequence 00,10,11,01,00 (each held 4 cycles) with count=3 -> exactly one inc pulse, at edge k+3; dec stays 0.
REQ-031 Entry sequence 10,11,10,00 (car backs out) -> no inc; entry FSM returns to IDLE.
REQ-032 count=25, full entry pass -> inc=0, ovf_err=1 and stays 1; full=1; ent_open=0 once the FSM is back in IDLE.
REQ-033 count=0, full exit pass -> dec=0, unf_err=1; empty=1.
REQ-034 Entry and exit passes completing on the same edge, count=10 -> inc=0, dec=0, no error flags set.
REQ-035 reset=0 asserted while the entry FSM is in F2 -> all outputs at REQ-026 values next cycle; no inc after reset is released.
